// File: rtl/sp_ram_arbiter_pkg.sv
// Shared types and defaults for the single-port RAM arbiter slice.
package sp_ram_arb_pkg;

    localparam int DEF_NREQ  = 2;
    localparam int DEF_DW    = 32;
    localparam int DEF_AW    = 10;
    localparam int DEF_DEPTH = 1024;

    // INIT clears the RAM after reset, ARB serves requesters.
    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } arb_state_e;

    // Low bit position of lane idx inside a packed bus of width-bit lanes.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sp_ram_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last winner.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   winner_o,
    output logic            valid_o
);

    logic [IW-1:0]   ptr_q;
    logic [NREQ-1:0] req_m;
    logic [IW-1:0]   idx;

    assign req_m = en_i ? req_i : '0;

    // Search upward from ptr+1, wrapping, and take the first pending request.
    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = IW'((int'(ptr_q) + off) % NREQ);
            if (!valid_o && req_m[idx]) begin
                valid_o    = 1'b1;
                winner_o   = idx;
                gnt_o[idx] = 1'b1;
            end
        end
    end

    // Pointer remembers the last winner; reset makes requester 0 the first pick.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IW'(NREQ - 1);
        end else if (valid_o) begin
            ptr_q <= winner_o;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port synchronous RAM between NREQ requesters.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int            NREQ           = DEF_NREQ,
    parameter int            DW             = DEF_DW,
    parameter int            AW             = DEF_AW,
    parameter int            DEPTH          = DEF_DEPTH,
    parameter int            CLEAR_ON_RESET = 1,
    parameter logic [DW-1:0] INIT_VAL       = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               init_done,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_data,
    output logic               ram_we,
    input  logic [DW-1:0]      ram_q
);

    localparam int            IW        = $clog2(NREQ);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    arb_state_e      state_q;
    logic [AW-1:0]   k_q;
    logic [AW-1:0]   k_d;
    logic            init_done_q;
    logic            ram_we_q;
    logic [AW-1:0]   ram_addr_q;
    logic [DW-1:0]   ram_data_q;
    logic            rd_vld1_q;
    logic [IW-1:0]   tag1_q;
    logic [NREQ-1:0] rvalid_q;

    logic            arb_en;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   winner;
    logic            grant_valid;
    logic            win_we;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;

    // No grant while clearing or while reset is being applied.
    assign arb_en = (state_q == ARB) && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .clk      (clk),
        .rst      (rst),
        .en_i     (arb_en),
        .req_i    (req),
        .gnt_o    (arb_gnt),
        .winner_o (winner),
        .valid_o  (grant_valid)
    );

    // Pull the winning requester's command out of the packed buses.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IW'(i)) begin
                win_we    = we[i];
                win_addr  = addr[slice_lo(i, AW) +: AW];
                win_wdata = wdata[slice_lo(i, DW) +: DW];
            end
        end
    end

    assign k_d = k_q + 1'b1;

    // Clear sweep, then register each granted command onto the RAM port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? INIT : ARB;
            k_q         <= '0;
            init_done_q <= (CLEAR_ON_RESET == 0);
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    ram_we_q   <= 1'b1;
                    ram_addr_q <= k_q;
                    ram_data_q <= INIT_VAL;
                    if (k_q == LAST_ADDR) begin
                        state_q     <= ARB;
                        init_done_q <= 1'b1;
                    end else begin
                        k_q <= k_d;
                    end
                end
                default: begin
                    if (grant_valid) begin
                        ram_we_q   <= win_we;
                        ram_addr_q <= win_addr;
                        ram_data_q <= win_wdata;
                    end else begin
                        ram_we_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Two-stage tag pipeline matching the RAM's registered read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld1_q <= 1'b0;
            tag1_q    <= '0;
            rvalid_q  <= '0;
        end else begin
            rd_vld1_q <= grant_valid && !win_we;
            tag1_q    <= winner;
            rvalid_q  <= rd_vld1_q ? (NREQ'(1) << tag1_q) : '0;
        end
    end

    assign gnt       = arb_gnt;
    assign rvalid    = rvalid_q;
    assign rdata     = ram_q;
    assign init_done = init_done_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter with a behavioural single-port RAM.
module tb_sp_ram_arbiter;

    localparam int NREQ  = 2;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: clear sweep enabled
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               initDone;
    logic [AW-1:0]      ramAddr;
    logic [DW-1:0]      ramData;
    logic               ramWe;
    logic [DW-1:0]      ramQ;

    // Instance B: no clear sweep
    logic               rstB;
    logic [NREQ-1:0]    reqB;
    logic [NREQ-1:0]    weB;
    logic [NREQ*AW-1:0] addrB;
    logic [NREQ*DW-1:0] wdataB;
    logic [NREQ-1:0]    gntB;
    logic [NREQ-1:0]    rvalidB;
    logic [DW-1:0]      rdataB;
    logic               initDoneB;
    logic [AW-1:0]      ramAddrB;
    logic [DW-1:0]      ramDataB;
    logic               ramWeB;
    logic [DW-1:0]      ramQB;

    sp_ram_arbiter #(
        .NREQ(NREQ), .DW(DW), .AW(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1), .INIT_VAL('0)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .init_done(initDone),
        .ram_addr(ramAddr), .ram_data(ramData), .ram_we(ramWe), .ram_q(ramQ)
    );

    sp_ram_arbiter #(
        .NREQ(NREQ), .DW(DW), .AW(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(0), .INIT_VAL('0)
    ) dutB (
        .clk(clk), .rst(rstB), .req(reqB), .we(weB), .addr(addrB), .wdata(wdataB),
        .gnt(gntB), .rvalid(rvalidB), .rdata(rdataB), .init_done(initDoneB),
        .ram_addr(ramAddrB), .ram_data(ramDataB), .ram_we(ramWeB), .ram_q(ramQB)
    );

    assign ramQB = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rrPtr = NREQ - 1;
    bit monOn = 1'b0;
    bit scrub = 1'b0;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] expMem [DEPTH];
    logic [1:0] monExp;

    typedef struct {
        int            tag;
        logic [DW-1:0] data;
        int            due;
    } sb_t;
    sb_t sbQ[$];

    // Behavioural RAM, pre-filled with junk so the clear sweep is observable
    always @(posedge clk) begin
        if (scrub) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5A5A5;
        end else if (ramWe) begin
            mem[ramAddr] <= ramData;
        end
        ramQ <= mem[ramAddr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Read returns must appear exactly on their due cycle, nothing otherwise
    always @(negedge clk) begin
        #2;
        if (monOn) begin
            total++;
            if (sbQ.size() > 0 && sbQ[0].due == cyc) begin
                monExp = 2'b01 << sbQ[0].tag;
                if (rvalid !== monExp || rdata !== sbQ[0].data) begin
                    bad++;
                    $display("[TB] FAIL read_return cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                             cyc, rvalid, rdata, monExp, sbQ[0].data);
                end
                void'(sbQ.pop_front());
            end else if (rvalid !== 2'b00) begin
                bad++;
                $display("[TB] FAIL unexpected_rvalid cyc=%0d got rvalid=%b want 00", cyc, rvalid);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int rrPick(input logic [1:0] r, input int p);
        for (int o = 1; o <= NREQ; o++) begin
            if (r[(p + o) % NREQ]) return (p + o) % NREQ;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        req   = r;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
    endtask

    // Record the effect of a granted command in the reference model
    task automatic pushExpect(input int w);
        logic [AW-1:0] a;
        rrPtr = w;
        a = addr[w*AW +: AW];
        if (we[w]) expMem[a] = wdata[w*DW +: DW];
        else sbQ.push_back('{w, expMem[a], cyc + 2});
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        scrub = 1'b1;
        applyStimulus(2'b11, 2'b00, 4'd0, 4'd0, '0, '0);
        repeat (2) @(posedge clk);
        scrub = 1'b0;
        #1;
        total++;
        if ({ramWe, ramAddr, ramData} !== '0) begin
            bad++; $display("[TB] FAIL reset_ram got we=%b addr=%h data=%h want 0", ramWe, ramAddr, ramData);
        end
        total++;
        if (rvalid !== 2'b00 || initDone !== 1'b0 || gnt !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_outputs got rvalid=%b done=%b gnt=%b want 00/0/00", rvalid, initDone, gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (gnt !== 2'b00 || ramWe !== 1'b0) begin
            bad++; $display("[TB] FAIL init_c0 got gnt=%b we=%b want 00/0", gnt, ramWe);
        end
        for (int c = 1; c <= DEPTH; c++) begin
            @(negedge clk);
            if (c == DEPTH) req = 2'b00;
            #1;
            total++;
            if (ramWe !== 1'b1 || ramAddr !== AW'(c - 1) || ramData !== '0) begin
                bad++; $display("[TB] FAIL init_sweep c=%0d got we=%b addr=%0d data=%h want 1/%0d/0", c, ramWe, ramAddr, ramData, c - 1);
            end
            if (c < DEPTH) begin
                total++;
                if (gnt !== 2'b00) begin
                    bad++; $display("[TB] FAIL init_gnt c=%0d got %b want 00", c, gnt);
                end
            end
            total++;
            if (initDone !== (c == DEPTH)) begin
                bad++; $display("[TB] FAIL init_done c=%0d got %b want %b", c, initDone, (c == DEPTH));
            end
        end
        for (int i = 0; i < DEPTH; i++) expMem[i] = '0;
        rrPtr = NREQ - 1;
        monOn = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (ramWe !== 1'b0 || initDone !== 1'b1) begin
            bad++; $display("[TB] FAIL post_init got we=%b done=%b want 0/1", ramWe, initDone);
        end
    endtask

    task automatic test_write_read();
        logic [1:0]    rq [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        logic [1:0]    wq [5] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [AW-1:0] aq [5] = '{4'd5, 4'd5, 4'd7, 4'd7, 4'd7};
        logic [1:0] expG;
        int w;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            applyStimulus(rq[s], wq[s], aq[s], 4'd0, 32'hDEADBEEF, '0);
            #1;
            w = rrPick(req, rrPtr);
            expG = (w < 0) ? 2'b00 : (2'b01 << w);
            total++;
            if (gnt !== expG) begin
                bad++; $display("[TB] FAIL wr_gnt step=%0d got %b want %b", s, gnt, expG);
            end
            if (s == 1) begin
                total++;
                if (ramWe !== 1'b1 || ramAddr !== 4'd5 || ramData !== 32'hDEADBEEF) begin
                    bad++; $display("[TB] FAIL wr_cmd got we=%b addr=%0d data=%h want 1/5/deadbeef", ramWe, ramAddr, ramData);
                end
            end
            if (s == 4) begin
                total++;
                if (ramWe !== 1'b0 || ramAddr !== 4'd7) begin
                    bad++; $display("[TB] FAIL idle_hold got we=%b addr=%0d want 0/7", ramWe, ramAddr);
                end
            end
            if (w >= 0) pushExpect(w);
        end
        for (int t = 0; t < 10 && sbQ.size() > 0; t++) @(posedge clk);
        total++;
        if (sbQ.size() != 0) begin
            bad++; $display("[TB] FAIL wr_drain got pending=%0d want 0", sbQ.size());
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]    rq [7] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        logic [1:0]    wq [7] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0]    gq [7] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [1:0] expG;
        int w;
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            applyStimulus(rq[s], wq[s], 4'd1, 4'd2, 32'h11111111, 32'h22222222);
            #1;
            w = rrPick(req, rrPtr);
            expG = (w < 0) ? 2'b00 : (2'b01 << w);
            total++;
            if (gnt !== expG || gnt !== gq[s]) begin
                bad++; $display("[TB] FAIL rr_gnt step=%0d got %b want %b", s, gnt, gq[s]);
            end
            if (w >= 0) pushExpect(w);
        end
        for (int t = 0; t < 10 && sbQ.size() > 0; t++) @(posedge clk);
        total++;
        if (sbQ.size() != 0) begin
            bad++; $display("[TB] FAIL rr_drain got pending=%0d want 0", sbQ.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] rq [3] = '{2'b10, 2'b01, 2'b00};
        logic [1:0] wq [3] = '{2'b10, 2'b00, 2'b00};
        logic [1:0] expG;
        int w;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            applyStimulus(rq[s], wq[s], 4'd3, 4'd3, '0, 32'h12345678);
            #1;
            w = rrPick(req, rrPtr);
            expG = (w < 0) ? 2'b00 : (2'b01 << w);
            total++;
            if (gnt !== expG) begin
                bad++; $display("[TB] FAIL hz_gnt step=%0d got %b want %b", s, gnt, expG);
            end
            if (w >= 0) pushExpect(w);
        end
        for (int t = 0; t < 10 && sbQ.size() > 0; t++) @(posedge clk);
        total++;
        if (sbQ.size() != 0) begin
            bad++; $display("[TB] FAIL hz_drain got pending=%0d want 0", sbQ.size());
        end
    endtask

    task automatic test_reset_drop();
        int w;
        @(negedge clk);
        applyStimulus(2'b01, 2'b00, 4'd5, 4'd0, '0, '0);
        #1;
        w = rrPick(req, rrPtr);
        total++;
        if (gnt !== 2'b01 || w != 0) begin
            bad++; $display("[TB] FAIL drop_gnt got %b want 01", gnt);
        end
        @(negedge clk);
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (rvalid !== 2'b00 || initDone !== 1'b0) begin
            bad++; $display("[TB] FAIL drop_rvalid got rvalid=%b done=%b want 00/0", rvalid, initDone);
        end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (ramWe !== 1'b1 || ramAddr !== AW'(c - 1)) begin
                bad++; $display("[TB] FAIL reinit c=%0d got we=%b addr=%0d want 1/%0d", c, ramWe, ramAddr, c - 1);
            end
        end
        for (int t = 0; t < 40 && initDone !== 1'b1; t++) @(posedge clk);
        total++;
        if (initDone !== 1'b1) begin
            bad++; $display("[TB] FAIL reinit_timeout got done=%b want 1", initDone);
        end
        for (int i = 0; i < DEPTH; i++) expMem[i] = '0;
        rrPtr = NREQ - 1;
    endtask

    task automatic test_no_clear();
        reqB   = 2'b00;
        weB    = 2'b00;
        addrB  = '0;
        wdataB = '0;
        rstB   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstB   = 1'b0;
        reqB   = 2'b01;
        weB    = 2'b01;
        addrB  = {4'd0, 4'd4};
        wdataB = {32'h0, 32'hCAFEF00D};
        #1;
        total++;
        if (initDoneB !== 1'b1 || gntB !== 2'b01) begin
            bad++; $display("[TB] FAIL noclear_c0 got done=%b gnt=%b want 1/01", initDoneB, gntB);
        end
        @(negedge clk);
        reqB = 2'b00;
        #1;
        total++;
        if (ramWeB !== 1'b1 || ramAddrB !== 4'd4 || ramDataB !== 32'hCAFEF00D) begin
            bad++; $display("[TB] FAIL noclear_c1 got we=%b addr=%0d data=%h want 1/4/cafef00d", ramWeB, ramAddrB, ramDataB);
        end
        @(negedge clk);
        #1;
        total++;
        if (ramWeB !== 1'b0) begin
            bad++; $display("[TB] FAIL noclear_idle got we=%b want 0", ramWeB);
        end
    endtask

    initial begin
        rstB   = 1'b1;
        reqB   = 2'b00;
        weB    = 2'b00;
        addrB  = '0;
        wdataB = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_back_to_back();
        test_reset_drop();
        test_no_clear();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
